psk_mod_mpsk: RTL and testbench

//  Parametrised M-PSK modulator (BPSK/QPSK/8PSK, selectable per symbol) between the AXIS symbol FIFO and the DUC.

---
 rtl/psk_mod_mpsk.sv | 236 +++++++++++++++++++++++
 tb/tb_psk_mod_mpsk.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/psk_mod_mpsk.sv
// M-PSK modulator (BPSK/QPSK/8PSK per symbol): rotates the (cos,sin) carrier by the Gray-mapped phase.
// Define PSK_MOD_MPSK_8PSK_EN to build 8PSK (mode 2) and the 45-degree multiplier path.
module psk_mod_mpsk #(
    parameter int WIDTH    = 12,
    parameter int BYTES    = 1,
    parameter int SPS_LOG2 = 4
) (
    input  logic                    clk_16M384,
    input  logic                    rst_16M384,
    input  logic [BYTES*8-1:0]      data_tdata,
    input  logic                    data_tvalid,
    output logic                    data_tready,
    input  logic                    data_tlast,
    input  logic [1:0]              data_tuser,
    input  logic signed [WIDTH-1:0] carrier_I,
    input  logic signed [WIDTH-1:0] carrier_Q,
    input  logic [SPS_LOG2-1:0]     DELAY_CNT,
    output logic signed [WIDTH-1:0] out_I,
    output logic signed [WIDTH-1:0] out_Q,
    output logic                    out_vld,
    output logic                    out_last,
    output logic                    out_sym_start,
    output logic [1:0]              out_mode,
    output logic [2:0]              out_bits,
    output logic                    out_err,
    output logic                    out_clk_sym
);
    localparam int SW = WIDTH + 1;

    typedef enum logic [1:0] {
        MODE_BPSK = 2'd0,
        MODE_QPSK = 2'd1,
        MODE_8PSK = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x);
        return (x == S_MIN) ? S_MAX : -x;
    endfunction

    logic [SPS_LOG2-1:0] cnt;
    logic                strobe;
    logic                xfer;

    assign strobe      = (cnt == DELAY_CNT);
    assign data_tready = strobe & ~rst_16M384;
    assign xfer        = data_tvalid & data_tready;
    assign out_clk_sym = cnt[SPS_LOG2-1];

    // Symbol decode: mapped phase index k in 45-degree steps, masked raw bits, error flag.
    mode_t      dec_mode;
    logic [2:0] dec_k;
    logic [2:0] dec_bits;
    logic       dec_err;
    logic [2:0] d;

    assign d        = data_tdata[2:0];
    assign dec_mode = mode_t'(data_tuser);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_k    = 3'd0;
        dec_bits = 3'd0;
        dec_err  = 1'b0;
        case (dec_mode)
            MODE_BPSK: begin
                dec_bits = {2'b00, d[0]};
                dec_k    = d[0] ? 3'd0 : 3'd4;
            end
            MODE_QPSK: begin
                dec_bits = {1'b0, d[1:0]};
                dec_k    = {d[1], d[1] ^ d[0], 1'b0};
            end
            MODE_8PSK: begin
                dec_bits = d;
`ifdef PSK_MOD_MPSK_8PSK_EN
                dec_k    = {d[2], d[2] ^ d[1], d[2] ^ d[1] ^ d[0]};
`else
                dec_err  = 1'b1;
`endif
            end
            default: dec_err = 1'b1;
        endcase
    end

    logic       sym_vld, sym_last, sym_err, sym_new;
    logic [1:0] sym_mode;
    logic [2:0] sym_bits, sym_k;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            cnt      <= '0;
            sym_vld  <= 1'b0;
            sym_last <= 1'b0;
            sym_err  <= 1'b0;
            sym_new  <= 1'b0;
            sym_mode <= 2'd0;
            sym_bits <= 3'd0;
            sym_k    <= 3'd0;
        end else begin
            cnt     <= cnt + 1'b1;
            sym_new <= 1'b0;
            if (strobe) begin
                sym_vld  <= xfer;
                sym_new  <= xfer;
                sym_last <= xfer & data_tlast;
                sym_err  <= xfer & dec_err;
                sym_mode <= xfer ? data_tuser : 2'd0;
                sym_bits <= xfer ? dec_bits : 3'd0;
                sym_k    <= xfer ? dec_k : 3'd0;
            end
        end
    end

    // Stage 1: carrier capture, zeroing for idle/error symbols, 45-degree pre-sums.
    logic signed [SW-1:0] ci_x, cq_x, s1_a, s1_b;
    logic                 s1_zero;

    assign ci_x    = SW'(carrier_I);
    assign cq_x    = SW'(carrier_Q);
    assign s1_zero = ~sym_vld | sym_err;

    always_comb begin
        s1_a = ci_x;
        s1_b = cq_x;
`ifdef PSK_MOD_MPSK_8PSK_EN
        if (sym_k[0]) begin
            s1_a = ci_x - cq_x;
            s1_b = ci_x + cq_x;
        end
`endif
        if (s1_zero) begin
            s1_a = '0;
            s1_b = '0;
        end
    end

    logic signed [SW-1:0] p1_a, p1_b;
    logic [1:0]           p1_m, p1_mode;
    logic [2:0]           p1_bits;
    logic                 p1_odd, p1_vld, p1_last, p1_err, p1_start;

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            p1_a     <= '0;
            p1_b     <= '0;
            p1_m     <= 2'd0;
            p1_odd   <= 1'b0;
            p1_vld   <= 1'b0;
            p1_last  <= 1'b0;
            p1_err   <= 1'b0;
            p1_start <= 1'b0;
            p1_mode  <= 2'd0;
            p1_bits  <= 3'd0;
        end else begin
            p1_a     <= s1_a;
            p1_b     <= s1_b;
            p1_m     <= sym_k[2:1];
            p1_odd   <= sym_k[0];
            p1_vld   <= sym_vld;
            p1_last  <= sym_last;
            p1_err   <= sym_err;
            p1_start <= sym_new;
            p1_mode  <= sym_mode;
            p1_bits  <= sym_bits;
        end
    end

    // Stage 2: optional K=cos(45) scaling with round-half-up and saturation, then m*90 rotation.
    logic signed [WIDTH-1:0] i0, q0, rot_i, rot_q;

`ifdef PSK_MOD_MPSK_8PSK_EN
    localparam int PW = SW + 16;
    localparam logic signed [15:0]   K45   = 16'sd23170;
    localparam logic signed [PW-1:0] RND   = {{(SW+1){1'b0}}, 15'h4000};
    localparam logic signed [PW-1:0] P_MAX = {{17{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {{18{1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] scale45(input logic signed [SW-1:0] x);
        logic signed [PW-1:0] p;
        p = (PW'(x) * PW'(K45) + RND) >>> 15;
        if (p > P_MAX)      return S_MAX;
        else if (p < P_MIN) return S_MIN;
        else                return p[WIDTH-1:0];
    endfunction

    assign i0 = p1_odd ? scale45(p1_a) : p1_a[WIDTH-1:0];
    assign q0 = p1_odd ? scale45(p1_b) : p1_b[WIDTH-1:0];

    logic unused_sig;
    assign unused_sig = ^{data_tdata[BYTES*8-1:3]};
`else
    assign i0 = p1_a[WIDTH-1:0];
    assign q0 = p1_b[WIDTH-1:0];

    logic unused_sig;
    assign unused_sig = ^{data_tdata[BYTES*8-1:3], p1_a[WIDTH], p1_b[WIDTH], p1_odd};
`endif

    always_comb begin
        rot_i = i0;
        rot_q = q0;
        case (p1_m)
            2'd1: begin rot_i = neg_sat(q0); rot_q = i0;          end
            2'd2: begin rot_i = neg_sat(i0); rot_q = neg_sat(q0); end
            2'd3: begin rot_i = q0;          rot_q = neg_sat(i0); end
            default: ;
        endcase
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            out_I         <= '0;
            out_Q         <= '0;
            out_vld       <= 1'b0;
            out_last      <= 1'b0;
            out_err       <= 1'b0;
            out_sym_start <= 1'b0;
            out_mode      <= 2'd0;
            out_bits      <= 3'd0;
        end else begin
            out_I         <= rot_i;
            out_Q         <= rot_q;
            out_vld       <= p1_vld;
            out_last      <= p1_last;
            out_err       <= p1_err;
            out_sym_start <= p1_start;
            out_mode      <= p1_mode;
            out_bits      <= p1_bits;
        end
    end
endmodule

// File: tb/tb_psk_mod_mpsk.sv
// Directed bench for psk_mod_mpsk: vector table per symbol plus reset, idle, carrier-latency and DELAY_CNT sequences.
module tb_psk_mod_mpsk;
    localparam int WIDTH = 12;
    localparam int SPS   = 16;
`ifdef PSK_MOD_MPSK_8PSK_EN
    localparam bit EN8 = 1'b1;
`else
    localparam bit EN8 = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [7:0]              data_tdata = '0;
    logic                    data_tvalid = 1'b0;
    logic                    data_tready;
    logic                    data_tlast = 1'b0;
    logic [1:0]              data_tuser = '0;
    logic signed [WIDTH-1:0] carrier_I = '0;
    logic signed [WIDTH-1:0] carrier_Q = '0;
    logic [3:0]              delay_cnt = 4'd3;
    logic signed [WIDTH-1:0] out_I, out_Q;
    logic                    out_vld, out_last, out_sym_start, out_err, out_clk_sym;
    logic [1:0]              out_mode;
    logic [2:0]              out_bits;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    psk_mod_mpsk #(.WIDTH(WIDTH), .BYTES(1), .SPS_LOG2(4)) dut (
        .clk_16M384(clk), .rst_16M384(rst),
        .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tready(data_tready),
        .data_tlast(data_tlast), .data_tuser(data_tuser),
        .carrier_I(carrier_I), .carrier_Q(carrier_Q), .DELAY_CNT(delay_cnt),
        .out_I(out_I), .out_Q(out_Q), .out_vld(out_vld), .out_last(out_last),
        .out_sym_start(out_sym_start), .out_mode(out_mode), .out_bits(out_bits),
        .out_err(out_err), .out_clk_sym(out_clk_sym)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tdata;
        logic       last;
        int         ci, cq;
        int         exp_i, exp_q;
        logic       exp_err;
        int         exp_bits;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [7:0] tdata, input logic last,
                                input int ci, input int cq, input int ei, input int eq,
                                input logic err, input int bits);
        vec_t v;
        v.mode = mode; v.tdata = tdata; v.last = last; v.ci = ci; v.cq = cq;
        v.exp_i = ei; v.exp_q = eq; v.exp_err = err; v.exp_bits = bits;
        return v;
    endfunction

    // Present a symbol, wait (bounded) for the strobe, then check its 16 samples and the idle sample after.
    task automatic run_vec(input int idx, input vec_t v, output int waited);
        waited      = -1;
        data_tdata  = v.tdata;
        data_tuser  = v.mode;
        data_tlast  = v.last;
        carrier_I   = WIDTH'(v.ci);
        carrier_Q   = WIDTH'(v.cq);
        data_tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_tready === 1'b1) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            check($sformatf("v%0d_tready_timeout", idx), 0, 1);
            data_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < SPS; s++) begin
            @(negedge clk);
            check($sformatf("v%0d_s%0d_I", idx, s), out_I, v.exp_i);
            check($sformatf("v%0d_s%0d_Q", idx, s), out_Q, v.exp_q);
            check($sformatf("v%0d_s%0d_vld", idx, s), out_vld, 1);
            check($sformatf("v%0d_s%0d_last", idx, s), out_last, v.last);
            check($sformatf("v%0d_s%0d_err", idx, s), out_err, v.exp_err);
            check($sformatf("v%0d_s%0d_mode", idx, s), out_mode, v.mode);
            check($sformatf("v%0d_s%0d_bits", idx, s), out_bits, v.exp_bits);
            check($sformatf("v%0d_s%0d_start", idx, s), out_sym_start, (s == 0));
            check($sformatf("v%0d_s%0d_clksym", idx, s), out_clk_sym,
                  ((32'(delay_cnt) + 3 + s) % SPS) >= 8);
        end
        @(negedge clk);
        check($sformatf("v%0d_idle_vld", idx), out_vld, 0);
        check($sformatf("v%0d_idle_I", idx), out_I, 0);
        check($sformatf("v%0d_idle_Q", idx), out_Q, 0);
        check($sformatf("v%0d_idle_start", idx), out_sym_start, 0);
    endtask

    initial begin
        int w, cnt_rdy, cnt_vld, gap;

        vecs[0]  = mk(2'd0, 8'hF1, 1'b0,  1000,     0,  1000,     0, 1'b0, 1);
        vecs[1]  = mk(2'd0, 8'h06, 1'b0,  1000,     0, -1000,     0, 1'b0, 0);
        vecs[2]  = mk(2'd1, 8'hA4, 1'b0,   800,   300,   800,   300, 1'b0, 0);
        vecs[3]  = mk(2'd1, 8'h01, 1'b0,   800,   300,  -300,   800, 1'b0, 1);
        vecs[4]  = mk(2'd1, 8'h03, 1'b0,   800,   300,  -800,  -300, 1'b0, 3);
        vecs[5]  = mk(2'd1, 8'h02, 1'b0,   800,   300,   300,  -800, 1'b0, 2);
        vecs[6]  = mk(2'd2, 8'h01, 1'b0,  1000,     0, EN8 ?   707 : 0, EN8 ?   707 : 0, !EN8, 1);
        vecs[7]  = mk(2'd2, 8'h02, 1'b0,  1000,     0, EN8 ?  -707 : 0, EN8 ?   707 : 0, !EN8, 2);
        vecs[8]  = mk(2'd2, 8'h06, 1'b0,   800,   300, EN8 ?  -800 : 0, EN8 ?  -300 : 0, !EN8, 6);
        vecs[9]  = mk(2'd2, 8'h01, 1'b0,  2047, -2048, EN8 ?  2047 : 0, EN8 ?    -1 : 0, !EN8, 1);
        vecs[10] = mk(2'd2, 8'h04, 1'b0,  2047, -2048, EN8 ?    -1 : 0, EN8 ? -2047 : 0, !EN8, 4);
        vecs[11] = mk(2'd0, 8'h00, 1'b0, -2048,     0,  2047,     0, 1'b0, 0);
        vecs[12] = mk(2'd3, 8'h05, 1'b0,  1000,   300,     0,     0, 1'b1, 0);
        vecs[13] = mk(2'd1, 8'h02, 1'b1,   800,   300,   300,  -800, 1'b0, 2);

        // Reset state with a live carrier: outputs must stay zero.
        carrier_I = 12'sd1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_I", out_I, 0);
        check("rst_vld", out_vld, 0);
        check("rst_tready", data_tready, 0);
        check("rst_clksym", out_clk_sym, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i], w);

        // Idle strobes: tready pulses once per period, no valid samples.
        repeat (4) @(negedge clk);
        cnt_rdy = 0;
        cnt_vld = 0;
        for (int i = 0; i < 2 * SPS; i++) begin
            @(negedge clk);
            if (data_tready) cnt_rdy++;
            if (out_vld || out_I != 0) cnt_vld++;
        end
        check("idle_tready_pulses", cnt_rdy, 2);
        check("idle_vld_samples", cnt_vld, 0);

        // Carrier latency: a change during cycle X appears at the output in cycle X+2.
        data_tdata = 8'h01; data_tuser = 2'd0; carrier_I = 12'sd100; carrier_Q = 12'sd0;
        data_tvalid = 1'b1;
        w = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_tready) begin w = i; break; end
        end
        check("lat_tready_seen", (w >= 0), 1);
        @(posedge clk);
        #1 data_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 carrier_I = 12'sd200;
        @(negedge clk);
        check("lat_c0", out_I, 100);
        @(negedge clk);
        check("lat_c1", out_I, 100);
        @(negedge clk);
        check("lat_c2", out_I, 200);

        // Reset mid-symbol: outputs clear next cycle, counter restarts, first transfer at cnt==DELAY_CNT.
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_pre_rst_vld", out_vld, 1);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_I", out_I, 0);
        check("mid_rst_vld", out_vld, 0);
        check("mid_rst_bits", out_bits, 0);
        check("mid_rst_clksym", out_clk_sym, 0);
        check("mid_rst_tready", data_tready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec(100, vecs[13], w);
        check("post_rst_first_strobe", w, 3);

        // DELAY_CNT change takes effect at the next compare.
        w = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_tready) begin w = i; break; end
        end
        check("dly_first_seen", (w >= 0), 1);
        delay_cnt = 4'd10;
        gap = -1;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (data_tready) begin gap = i; break; end
        end
        check("dly_gap_3_to_10", gap, 7);
        delay_cnt = 4'd3;
        gap = -1;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (data_tready) begin gap = i; break; end
        end
        check("dly_gap_10_to_3", gap, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
